// File: rtl/writebuf_fsm_onedelay.sv
// Write-side controller for the packet line buffer.
// AXI-Stream slave for ingress bytes; drives the BRAM write port with
// registered outputs one cycle after acceptance and commits each completed
// line to the CountersBlock. Over-long packets are consumed and dropped.
module writebuf_fsm_onedelay #(
  parameter int DATA_WIDTH      = 8,
  parameter int CHAR_ADDR_WIDTH = 11,
  parameter int MAX_CHARS       = 1518
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_WIDTH-1:0]      s_tdata,
  input  logic                       s_tvalid,
  input  logic                       s_tlast,
  output logic                       s_tready,
  input  logic                       redflag,
  output logic                       wr_en,
  output logic [CHAR_ADDR_WIDTH-1:0] wr_char_addr,
  output logic [DATA_WIDTH-1:0]      wr_data,
  output logic                       wr_newline,
  output logic [CHAR_ADDR_WIDTH:0]   wr_len,
  output logic                       ovf
);

  // One extra bit so the counter can reach MAX_CHARS itself, which is the
  // marker that the next beat overflows the line.
  localparam int CW = CHAR_ADDR_WIDTH + 1;
  localparam logic [CW-1:0] MAX_C = CW'(MAX_CHARS);

  typedef enum logic [1:0] {IDLE, RECV, DISCARD, COMMIT} state_t;

  state_t                     state_q, state_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic                       wr_en_q, wr_en_d;
  logic [CHAR_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]      data_q, data_d;
  logic                       nl_q, nl_d;
  logic [CW-1:0]              len_q, len_d;
  logic                       ovf_q, ovf_d;

  logic accept;
  logic do_write;

  // IDLE only takes a new packet when a free line exists; once a line is
  // owned redflag no longer matters. COMMIT is a one-cycle bubble so redflag
  // can catch up before the next packet.
  assign s_tready = (state_q == IDLE) ? ~redflag : (state_q != COMMIT);
  assign accept   = s_tvalid & s_tready;
  assign do_write = accept & ((state_q == IDLE) | ((state_q == RECV) & (cnt_q < MAX_C)));

  // Next-state and registered write-port values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_en_d = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    nl_d    = 1'b0;
    len_d   = len_q;
    ovf_d   = 1'b0;
    case (state_q)
      RECV: begin
        if (accept && !do_write) begin
          // Line is full: drop this beat and the rest of the packet.
          ovf_d   = 1'b1;
          cnt_d   = '0;
          state_d = s_tlast ? IDLE : DISCARD;
        end
      end
      DISCARD: if (accept && s_tlast) state_d = IDLE;
      COMMIT:  state_d = IDLE;
      default: ;
    endcase
    if (do_write) begin
      wr_en_d = 1'b1;
      addr_d  = cnt_q[CHAR_ADDR_WIDTH-1:0];
      data_d  = s_tdata;
      cnt_d   = cnt_q + 1'b1;
      state_d = RECV;
      if (s_tlast) begin
        // Commit lands in the same cycle as the last byte's write.
        nl_d    = 1'b1;
        len_d   = cnt_q + 1'b1;
        cnt_d   = '0;
        state_d = COMMIT;
      end
    end
  end

  // State and output registers; reset abandons any partial line.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      nl_q    <= 1'b0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_en_q <= wr_en_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      nl_q    <= nl_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
    end
  end

  assign wr_en        = wr_en_q;
  assign wr_char_addr = addr_q;
  assign wr_data      = data_q;
  assign wr_newline   = nl_q;
  assign wr_len       = len_q;
  assign ovf          = ovf_q;

endmodule

// File: tb/tb_writebuf_fsm_onedelay.sv
// Randomized bench for writebuf_fsm_onedelay against a packet-level model.
module tb_writebuf_fsm_onedelay;
  localparam int DW   = 8;
  localparam int AW   = 11;
  localparam int MAXC = 1518;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tlast = 1'b0;
  logic          s_tready;
  logic          redflag = 1'b0;
  logic          wr_en;
  logic [AW-1:0] wr_char_addr;
  logic [DW-1:0] wr_data;
  logic          wr_newline;
  logic [AW:0]   wr_len;
  logic          ovf;

  writebuf_fsm_onedelay #(.DATA_WIDTH(DW), .CHAR_ADDR_WIDTH(AW), .MAX_CHARS(MAXC)) dut (
    .clk(clk), .rst(rst), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
    .s_tready(s_tready), .redflag(redflag), .wr_en(wr_en), .wr_char_addr(wr_char_addr),
    .wr_data(wr_data), .wr_newline(wr_newline), .wr_len(wr_len), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Packet-level model: bytes so far in the line, whether a line is owned,
  // whether the rest of an over-long packet is being dropped, commit bubble.
  int m_pos   = 0;
  bit m_inpkt = 0;
  bit m_drop  = 0;
  bit m_gap   = 0;
  bit after_rst = 1;

  // Expected registered outputs for the coming cycle.
  bit       e_wr_en = 0;
  int       e_addr  = 0;
  int       e_data  = 0;
  bit       e_nl    = 0;
  int       e_len   = 0;
  bit       e_ovf   = 0;

  // Observed event counts.
  int n_wr = 0, n_nl = 0, n_ovf = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: check last edge's outputs, drive inputs, predict.
  task automatic step(input logic v, input logic [7:0] d, input logic l,
                      input logic rf, input logic r, output logic acc);
    logic tr;
    @(negedge clk);
    chk("wr_en", {31'd0, wr_en}, {31'd0, e_wr_en});
    if (e_wr_en || after_rst) begin
      chk("wr_char_addr", {21'd0, wr_char_addr}, e_addr);
      chk("wr_data", {24'd0, wr_data}, e_data);
    end
    chk("wr_newline", {31'd0, wr_newline}, {31'd0, e_nl});
    if (e_nl || after_rst) chk("wr_len", {20'd0, wr_len}, e_len);
    chk("ovf", {31'd0, ovf}, {31'd0, e_ovf});
    if (wr_en === 1'b1) n_wr++;
    if (wr_newline === 1'b1) n_nl++;
    if (ovf === 1'b1) n_ovf++;

    s_tvalid = v; s_tdata = d; s_tlast = l; redflag = rf; rst = r;
    #1;
    tr = m_gap ? 1'b0 : (m_inpkt ? 1'b1 : ~rf);
    chk("s_tready", {31'd0, s_tready}, {31'd0, tr});
    acc = !r && v && tr;

    after_rst = r;
    if (r) begin
      m_pos = 0; m_inpkt = 0; m_drop = 0; m_gap = 0;
      e_wr_en = 0; e_addr = 0; e_data = 0; e_nl = 0; e_len = 0; e_ovf = 0;
    end else begin
      e_wr_en = 0; e_nl = 0; e_ovf = 0; m_gap = 0;
      if (acc) begin
        if (m_drop) begin
          if (l) begin m_drop = 0; m_inpkt = 0; end
        end else if (m_pos < MAXC) begin
          e_wr_en = 1; e_addr = m_pos; e_data = int'(d);
          m_pos++; m_inpkt = 1;
          if (l) begin
            e_nl = 1; e_len = m_pos; m_pos = 0; m_inpkt = 0; m_gap = 1;
          end
        end else begin
          e_ovf = 1; m_pos = 0;
          if (l) m_inpkt = 0; else m_drop = 1;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, a);
  endtask

  // Send len beats; tlast on the final beat only if with_last.
  task automatic send(input int len, input bit with_last, input int gap_pct,
                      input int red_pct, input bit rnd_data, input logic [7:0] base);
    logic a, v, rf;
    logic [7:0] d;
    int tries;
    for (int i = 0; i < len; i++) begin
      tries = 0;
      d = rnd_data ? 8'($urandom) : base + 8'(i);
      do begin
        v  = ($urandom_range(99) >= gap_pct);
        rf = (red_pct > 0) && ($urandom_range(99) < red_pct);
        step(v, d, with_last && (i == len - 1), rf, 1'b0, a);
        tries++;
        if (!a && tries > 2000) begin
          chk("beat_timeout", 32'd1, 32'd0);
          return;
        end
      end while (!a);
    end
  endtask

  int w0, n0, o0;
  task automatic mark();
    w0 = n_wr; n0 = n_nl; o0 = n_ovf;
  endtask
  task automatic deltas(input string tag, input int w, input int n, input int o);
    chk({tag, "_writes"}, n_wr - w0, w);
    chk({tag, "_commits"}, n_nl - n0, n);
    chk({tag, "_ovf"}, n_ovf - o0, o);
  endtask

  initial begin
    logic a;
    // Reset state.
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, a);
    idle(2);

    // Back-to-back 4-byte packet A0..A3.
    mark(); send(4, 1, 0, 0, 0, 8'hA0); idle(2); deltas("pkt4", 4, 1, 0);

    // redflag holds off a new packet, then released.
    mark();
    for (int i = 0; i < 10; i++) step(1'b1, 8'h11, 1'b0, 1'b1, 1'b0, a);
    deltas("red_hold", 0, 0, 0);
    send(3, 1, 0, 0, 0, 8'h11); idle(2); deltas("red_rel", 3, 1, 0);

    // Single-beat packet.
    mark(); send(1, 1, 0, 0, 0, 8'h5C); idle(2); deltas("single", 1, 1, 0);

    // Over-long packet then a short one reusing the line.
    mark(); send(MAXC + 2, 1, 0, 0, 1, 8'h00); idle(2); deltas("ovf", MAXC, 0, 1);
    mark(); send(3, 1, 0, 0, 0, 8'h30); idle(2); deltas("after_ovf", 3, 1, 0);

    // Exactly max-length packet.
    mark(); send(MAXC, 1, 0, 0, 1, 8'h00); idle(2); deltas("maxlen", MAXC, 1, 0);

    // Reset in the middle of a packet.
    mark();
    send(5, 0, 0, 0, 0, 8'h60);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, a);
    send(5, 1, 0, 0, 0, 8'h65);
    idle(2); deltas("midrst", 10, 1, 0);

    // 64-byte packet with 50% valid gaps.
    mark(); send(64, 1, 50, 0, 1, 8'h00); idle(2); deltas("gaps64", 64, 1, 0);

    // Random packets, gaps and redflag activity.
    for (int p = 0; p < 30; p++) begin
      send($urandom_range(40, 1), 1, $urandom_range(60), 20, 1, 8'h00);
      idle($urandom_range(3));
    end
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
